// File: rtl/resize_sequencer_pkg.sv
// Shared definitions for the resize sequencer: fixed-point widths,
// FSM state encoding and the dimension/accumulator types.
package pkg_resize;

  localparam int FIXED      = 11;
  localparam int DIM_W      = 12;
  localparam int SF_W       = DIM_W + FIXED;
  localparam int HALF_PIXEL = 1 << (FIXED - 1);

  typedef enum logic [2:0] {
    S_Reset,
    S_Ready,
    S_StartCalcSF,
    S_StartPixelGen,
    S_Index,
    S_Done
  } STATES_t;

  typedef logic [DIM_W-1:0] dim_t;
  typedef logic [SF_W-1:0]  sf_t;

  // One extra bit so the center-aligned start offset can go negative;
  // in corner-aligned builds the top bit simply stays zero.
  typedef logic signed [SF_W:0] acc_t;

endpackage

// File: rtl/resize_sequencer_sf_divider.sv
// Serial restoring divider, one quotient bit per cycle.
// A load takes one cycle, then SF_W iterations follow; o_done pulses for
// one cycle when the quotient is final and a new load is accepted then.
module resize_sf_divider #(
  parameter int SF_W = 23
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_load,
  input  logic [SF_W-1:0] i_dividend,
  input  logic [SF_W-1:0] i_divisor,
  output logic            o_busy,
  output logic            o_done,
  output logic [SF_W-1:0] o_quotient
);

  localparam int CNT_W = $clog2(SF_W + 1);

  logic [SF_W-1:0]  r_quo;
  logic [SF_W:0]    r_rem;
  logic [SF_W-1:0]  r_div;
  logic [CNT_W-1:0] r_count;
  logic             r_busy;
  logic             r_done;

  logic [SF_W+1:0]  w_remShift;
  logic [SF_W+1:0]  w_diff;
  logic             w_fits;

  assign w_remShift = {r_rem, r_quo[SF_W-1]};
  assign w_diff     = w_remShift - {2'b00, r_div};
  assign w_fits     = ~w_diff[SF_W+1];

  // Shift the next dividend bit into the remainder and subtract when it fits
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_quo   <= '0;
      r_rem   <= '0;
      r_div   <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (i_load) begin
      r_quo   <= i_dividend;
      r_rem   <= '0;
      r_div   <= i_divisor;
      r_count <= CNT_W'(SF_W);
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else if (r_busy) begin
      r_rem   <= w_fits ? w_diff[SF_W:0] : w_remShift[SF_W:0];
      r_quo   <= {r_quo[SF_W-2:0], w_fits};
      r_count <= r_count - CNT_W'(1);
      if (r_count == CNT_W'(1)) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end else begin
        r_done <= 1'b0;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_quotient = r_quo;

endmodule

// File: rtl/resize_sequencer.sv
// Resize engine control: computes fixed-point scale factors on a shared
// serial divider, then walks the destination raster and streams one
// source coordinate (integer + fraction) per destination pixel.
// Optional build macro RESIZE_CENTER_ALIGN_EN selects half-pixel-center
// mapping; without it the mapping is corner aligned.
module resize_sequencer
  import pkg_resize::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIM_W-1:0] src_w,
  input  logic [DIM_W-1:0] src_h,
  input  logic [DIM_W-1:0] dst_w,
  input  logic [DIM_W-1:0] dst_h,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DIM_W-1:0] out_src_x,
  output logic [DIM_W-1:0] out_src_y,
  output logic [FIXED-1:0] out_frac_x,
  output logic [FIXED-1:0] out_frac_y,
  output logic             out_last
);

  STATES_t r_state;
  STATES_t w_nextState;

  dim_t r_srcW, r_srcH, r_dstW, r_dstH;
  logic r_busy, r_done, r_err;

  logic r_divPending;
  logic r_sfPhase;
  sf_t  r_sfX, r_sfY;

  dim_t r_x, r_y;
  acc_t r_accX, r_accY;

  logic r_outValid, r_outLast;
  dim_t r_outSrcX, r_outSrcY;
  logic [FIXED-1:0] r_outFracX, r_outFracY;

  logic w_zeroDim;
  logic w_handshake;
  logic w_loadCoord;
  logic w_divLoad, w_divBusy, w_divDone, w_selY;
  sf_t  w_divDividend, w_divDivisor, w_divQuot;
  acc_t w_initX, w_initY;
  dim_t w_xNext, w_yNext;
  acc_t w_accXNext, w_accYNext;

  // Integer part of an accumulator, clamped to the last source pixel
  function automatic dim_t accToInt(input acc_t acc, input dim_t srcDim);
    dim_t intPart;
    if (acc[SF_W]) begin
      intPart = '0;
    end else begin
      intPart = acc[SF_W-1:FIXED];
      if (intPart > srcDim - dim_t'(1)) intPart = srcDim - dim_t'(1);
    end
    return intPart;
  endfunction

  // Fractional weight of an accumulator; a negative position reads as zero
  function automatic logic [FIXED-1:0] accToFrac(input acc_t acc);
    return acc[SF_W] ? '0 : acc[FIXED-1:0];
  endfunction

  assign w_zeroDim   = (dst_w == '0) || (dst_h == '0);
  assign w_handshake = r_outValid && out_ready;
  assign w_loadCoord = (r_state == S_StartPixelGen) || (w_handshake && !r_outLast);

  // X is divided first; the Y load is issued in the same cycle X finishes
  assign w_selY        = w_divDone && !r_sfPhase;
  assign w_divLoad     = (r_state == S_StartCalcSF) && !w_divBusy && (r_divPending || w_selY);
  assign w_divDividend = w_selY ? {r_srcH, {FIXED{1'b0}}} : {r_srcW, {FIXED{1'b0}}};
  assign w_divDivisor  = w_selY ? {{(SF_W-DIM_W){1'b0}}, r_dstH}
                                : {{(SF_W-DIM_W){1'b0}}, r_dstW};

`ifdef RESIZE_CENTER_ALIGN_EN
  assign w_initX = acc_t'({2'b00, r_sfX[SF_W-1:1]}) - acc_t'(HALF_PIXEL);
  assign w_initY = acc_t'({2'b00, r_sfY[SF_W-1:1]}) - acc_t'(HALF_PIXEL);
`else
  assign w_initX = '0;
  assign w_initY = '0;
`endif

  resize_sf_divider #(
    .SF_W (SF_W)
  ) u_divider (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_load     (w_divLoad),
    .i_dividend (w_divDividend),
    .i_divisor  (w_divDivisor),
    .o_busy     (w_divBusy),
    .o_done     (w_divDone),
    .o_quotient (w_divQuot)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_Reset;
    else        r_state <= w_nextState;
  end

  // Next-state decode
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_Reset:         w_nextState = S_Ready;
      S_Ready:         if (start) w_nextState = w_zeroDim ? S_Done : S_StartCalcSF;
      S_StartCalcSF:   if (w_divDone && r_sfPhase) w_nextState = S_StartPixelGen;
      S_StartPixelGen: w_nextState = S_Index;
      S_Index:         if (w_handshake && r_outLast) w_nextState = S_Done;
      S_Done:          w_nextState = S_Ready;
      default:         w_nextState = S_Reset;
    endcase
  end

  // Raster walk: next counter and accumulator values for the coming pixel
  always_comb begin
    w_xNext    = r_x;
    w_yNext    = r_y;
    w_accXNext = r_accX;
    w_accYNext = r_accY;
    if (r_state == S_StartPixelGen) begin
      w_xNext    = '0;
      w_yNext    = '0;
      w_accXNext = w_initX;
      w_accYNext = w_initY;
    end else if (w_handshake) begin
      if (r_x < r_dstW - dim_t'(1)) begin
        w_xNext    = r_x + dim_t'(1);
        w_accXNext = r_accX + acc_t'({1'b0, r_sfX});
      end else begin
        w_xNext    = '0;
        w_accXNext = w_initX;
        w_yNext    = r_y + dim_t'(1);
        w_accYNext = r_accY + acc_t'({1'b0, r_sfY});
      end
    end
  end

  // Job capture and status flags, all registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_srcW <= '0;
      r_srcH <= '0;
      r_dstW <= '0;
      r_dstH <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == S_Ready && start) begin
        r_srcW <= src_w;
        r_srcH <= src_h;
        r_dstW <= dst_w;
        r_dstH <= dst_h;
        r_err  <= w_zeroDim;
      end
      r_busy <= (w_nextState != S_Reset) && (w_nextState != S_Ready);
      r_done <= (w_nextState == S_Done);
    end
  end

  // Scale-factor sequencing around the shared divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_divPending <= 1'b0;
      r_sfPhase    <= 1'b0;
      r_sfX        <= '0;
      r_sfY        <= '0;
    end else begin
      if (r_state == S_Ready && start) begin
        r_divPending <= !w_zeroDim;
        r_sfPhase    <= 1'b0;
      end else if (w_divLoad) begin
        r_divPending <= 1'b0;
      end
      if (r_state == S_StartCalcSF && w_divDone) begin
        if (r_sfPhase) begin
          r_sfY <= w_divQuot;
        end else begin
          r_sfX     <= w_divQuot;
          r_sfPhase <= 1'b1;
        end
      end
    end
  end

  // Registered coordinate stream; held steady while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x        <= '0;
      r_y        <= '0;
      r_accX     <= '0;
      r_accY     <= '0;
      r_outValid <= 1'b0;
      r_outLast  <= 1'b0;
      r_outSrcX  <= '0;
      r_outSrcY  <= '0;
      r_outFracX <= '0;
      r_outFracY <= '0;
    end else begin
      r_outValid <= (w_nextState == S_Index);
      if (w_loadCoord) begin
        r_x        <= w_xNext;
        r_y        <= w_yNext;
        r_accX     <= w_accXNext;
        r_accY     <= w_accYNext;
        r_outSrcX  <= accToInt(w_accXNext, r_srcW);
        r_outSrcY  <= accToInt(w_accYNext, r_srcH);
        r_outFracX <= accToFrac(w_accXNext);
        r_outFracY <= accToFrac(w_accYNext);
        r_outLast  <= (w_xNext == r_dstW - dim_t'(1)) && (w_yNext == r_dstH - dim_t'(1));
      end else if (w_handshake) begin
        r_outLast  <= 1'b0;
      end
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign out_valid  = r_outValid;
  assign out_last   = r_outLast;
  assign out_src_x  = r_outSrcX;
  assign out_src_y  = r_outSrcY;
  assign out_frac_x = r_outFracX;
  assign out_frac_y = r_outFracY;

endmodule

// File: doc/resize_sequencer.md
# resize_sequencer

Control block for the image resize engine. Accepts a job (source and destination dimensions) and computes fixed-point horizontal and vertical scale factors with a shared serial divider. It then walks the destination raster and emits, per destination pixel, the source coordinate (integer plus FIXED-bit fraction) over a valid/ready stream. It sits between the host/config logic and the pixel interpolator datapath.

## Interface
- DIM_W, 12: width of every image dimension and integer coordinate.
- SF_W, DIM_W+FIXED: width of scale factors and coordinate accumulators (FIXED = 11, from pkg_resize).
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- start, input, 1: job request, sampled only in S_Ready.
- src_w, src_h, input, DIM_W each: source dimensions, latched on accepted start.
- dst_w, dst_h, input, DIM_W each: destination dimensions, latched on accepted start.
- busy, output, 1: high from the cycle after start is accepted through S_Done.
- done, output, 1: one-cycle pulse in S_Done.
- err, output, 1: set in S_Done when dst_w or dst_h was 0; cleared on next accepted start.
- out_valid, output, 1: coordinate available.
- out_ready, input, 1: downstream accepts.
- out_src_x, out_src_y, output, DIM_W each: integer source coordinate.
- out_frac_x, out_frac_y, output, FIXED each: fractional weight.
- out_last, output, 1: marks the final pixel of the job.
- Reset values: busy=0, done=0, err=0, out_valid=0, out_last=0, all coordinate outputs 0, state=S_Reset.

## Operation
- S_Reset: entered on reset. Moves to S_Ready on the first clock after rst_n deasserts.
- S_Ready: start=1 latches dims and goes to S_StartCalcSF. If dst_w==0 or dst_h==0, go to S_Done with err=1 instead.
- S_StartCalcSF: sf_x = (src_w<<FIXED)/dst_w, then sf_y = (src_h<<FIXED)/dst_h, both on one divider, sequentially. Quotient is truncated. Go to S_StartPixelGen when the second divide is done.
- S_StartPixelGen: clear x and y counters. Set acc_x and acc_y to their initial value (0, or the center-aligned offset). One cycle, then S_Index.
- S_Index: out_valid=1. Coordinates are derived from acc_x/acc_y: integer part is acc>>FIXED, clamped to src-1; fraction is acc[FIXED-1:0].
- On each handshake (out_valid && out_ready):
  - If x < dst_w-1: x++ and acc_x += sf_x.
  - Otherwise: x=0, acc_x=initial, y++, acc_y += sf_y.
- On the handshake where out_last is high (x==dst_w-1 and y==dst_h-1), go to S_Done.
- S_Done: done=1 for one cycle, then S_Ready.
- start outside S_Ready is ignored. Dims are not re-sampled mid-job.
- Accumulators need no overflow handling: (dst-1)*sf < src<<FIXED, so they fit in SF_W.

## Timing
- Divider is restoring, 1 quotient bit per cycle, SF_W+1 cycles per divide including load.
- start→first out_valid: 1 + 2*(SF_W+1) + 1 cycles (50 cycles at the default widths).
- Outputs are registered. While out_valid && !out_ready, all out_* stay stable.
- Throughput is one coordinate per cycle under continuous out_ready.
- After the last handshake, out_valid drops in the next cycle and done pulses in that same cycle.
- Reset mid-job: asynchronous return to S_Reset with all outputs at reset values. No partial done.

## Configuration
- RESIZE_CENTER_ALIGN_EN defined: use half-pixel-center mapping src = (dst+0.5)*sf − 0.5.
  - Initial acc = (sf>>1) − (1<<(FIXED-1)), held as a signed SF_W+1 value.
  - A negative acc outputs integer 0, fraction 0.
- Not defined: corner-aligned mapping src = dst*sf. Initial acc = 0 and accumulators are unsigned.

## Structure
- pkg_resize owns FIXED, STATES_t (S_Reset, S_Ready, S_StartCalcSF, S_StartPixelGen, S_Index, S_Done) and any shared dimension typedefs.
- Sub-module resize_sf_divider: serial unsigned divider with a load/busy/done handshake, parameterized by SF_W. It is instantiated once and reused for X then Y.

## Test plan
- Upscale 4x4→8x8: sf_x=sf_y=1024. Row 0 x sequence int/frac = 0/0, 0/1024, 1/0, 1/1024 … 3/1024. 64 coordinates, out_last on the 64th, done 1 cycle later.
- Downscale 8x8→4x4: sf=4096. out_src_x = 0, 2, 4, 6 with frac 0. out_src_y steps 0, 2, 4, 6 per row.
- Non-integer 3x1→2x1: sf_x=3072. Outputs 0/0 then 1/1024 with out_last on the second.
- Zero dimension dst_w=0: no out_valid, done pulses with err=1 within 2 cycles of start. The next valid job clears err.
- Backpressure: hold out_ready low for 5 cycles mid-row → outputs stable, no skipped or duplicated coordinates. Also assert rst_n low mid-S_Index → all outputs 0, state S_Ready one cycle after release.
- RESIZE_CENTER_ALIGN_EN, 4→8: x=0 outputs 0/0 (clamped from −512), x=1 outputs 0/512, x=7 outputs 3/512.
